muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle RV32M multiply/divide engine with a START/BUSY/DONE handshake.
//  Executes all 8 M-extension ops with exact RISC-V semantics, including the
//  divide-by-zero and signed-overflow cases. Sits beside the EX-stage ALU; the
//  pipeline stalls on BUSY and captures RESULT on DONE.
//  Parametrised in data width and multiplier radix; FLUSH aborts an operation.
// PARAMETERS
//  XLEN      32  operand/result width; must be a multiple of MUL_STEP
//  MUL_STEP  4   multiplier bits retired per cycle (1,2,4,8); mul iterations = XLEN/MUL_STEP
// PORTS
//  CLK       in   1     clock, rising edge
//  RESET     in   1     synchronous, active-high
//  START     in   1     launch op; sampled only in IDLE
//  FUNCT3    in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  OPERAND1  in   XLEN  rs1 value (multiplicand / dividend)
//  OPERAND2  in   XLEN  rs2 value (multiplier / divisor)
//  FLUSH     in   1     synchronous abort (branch flush)
//  BUSY      out  1     operation in progress
//  DONE      out  1     one-cycle pulse; RESULT valid in that cycle
//  RESULT    out  XLEN  result; held until the next accepted START
// BEHAVIOUR
//  Reset: state IDLE, BUSY=0, DONE=0, RESULT=0, counter=0. Reset mid-op discards the op.
//  FSM IDLE -> CALC -> FIN -> IDLE.
//   IDLE: START=1 & FLUSH=0 -> latch FUNCT3 and operand magnitudes/signs.
//         Normal ops go to CALC. Special divide cases go straight to FIN.
//   CALC: BUSY=1. One iteration per cycle.
//         Mul: shift-add of MUL_STEP bits/cycle into a 2*XLEN accumulator.
//         Div: restoring radix-2, one quotient bit/cycle, XLEN cycles.
//         Last iteration -> FIN.
//   FIN:  DONE=1, BUSY=0, RESULT drives the final value; next cycle -> IDLE.
//  Latency (START edge to the DONE cycle):
//   mul = XLEN/MUL_STEP+1 (9 at defaults); div/rem = XLEN+1 (33); special cases = 1.
//  The earliest next START is the cycle after DONE.
//  START outside IDLE is ignored; the pipeline must hold START until DONE.
//  FLUSH in CALC/FIN: next state IDLE, no DONE pulse, RESULT keeps its previous value.
//  START and FLUSH in the same cycle: FLUSH wins and nothing is launched.
//  Sign rules:
//   Operands are converted to magnitudes before iterating.
//   MUL/MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU/DIVU/REMU: unsigned.
//   Product negated over 2*XLEN when the operand signs differ.
//   MUL returns prod[XLEN-1:0]; MULH* return prod[2*XLEN-1:XLEN].
//   Quotient sign = sign1^sign2; remainder sign = dividend sign.
//  Special cases (resolved in IDLE, no iteration):
//   divisor=0:   DIV/DIVU -> all ones; REM/REMU -> OPERAND1.
//   DIV/REM with OPERAND1 = 1<<(XLEN-1) and OPERAND2 = all ones:
//                quotient = OPERAND1, remainder = 0.
//  Widths: the counter is $clog2(XLEN)+1 bits; no arithmetic wraps except the
//  intended XLEN truncation of results.
// STRUCTURE
//  Shared package muldiv_pkg:
//   FUNCT3 localparams (F3_MUL..F3_REMU) and the state enum {IDLE,CALC,FIN}.
//   Also used by control_unit to decode M ops.
//  One sub-module, div_iter_core: restoring divider step
//   (partial remainder, quotient shift, subtract/restore), instantiated once.
//  Mul datapath, sign fix-up and FSM stay in muldiv_unit.
// TESTING
//  1 MUL 7 x 0xFFFFFFFD -> RESULT 0xFFFFFFEB, DONE exactly 9 cycles after START, BUSY high 8 cycles.
//  2 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000;
//    MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
//  3 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; each DONE at cycle 33.
//  4 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0;
//    DONE one cycle after START, BUSY never high.
//  5 FLUSH at CALC cycle 10 of a DIV -> no DONE, BUSY low next cycle, RESULT unchanged;
//    START next cycle runs normally.
//  6 RESET asserted mid-MUL -> next cycle BUSY=0, DONE=0, RESULT=0;
//    START+FLUSH together in IDLE -> no launch.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared RV32M definitions: FUNCT3 encodings, engine state, operand-sign decode.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is signed for MUL, MULH, MULHSU, DIV, REM
  function automatic logic rs1_signed(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
  endfunction

  // rs2 is signed for MUL, MULH, DIV, REM
  function automatic logic rs2_signed(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : ~f3[1];
  endfunction

endpackage

// File: rtl/muldiv_div_iter_core.sv
// One restoring radix-2 divide step: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only when it did not borrow.
module div_iter_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor_i};
  // Top bit of the XLEN+1 difference is the borrow: set means "restore".
  assign fits    = ~diff[XLEN];
  assign rem_o   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_o   = {quo_i[XLEN-2:0], fits};

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide engine with START/BUSY/DONE handshake.
// Iterates on magnitudes in one shared 2*XLEN accumulator, then fixes signs.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int              CW        = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   MUL_ITERS = CW'(XLEN / MUL_STEP);
  localparam logic [CW-1:0]   DIV_ITERS = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                neg_q, neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;

  // Launch-time decode straight from the request inputs.
  logic                sign1, sign2;
  logic [XLEN-1:0]     mag1, mag2;
  logic                div_by_zero, div_ovf;
  logic [XLEN-1:0]     special_res;

  assign sign1       = rs1_signed(FUNCT3) & OPERAND1[XLEN-1];
  assign sign2       = rs2_signed(FUNCT3) & OPERAND2[XLEN-1];
  assign mag1        = sign1 ? -OPERAND1 : OPERAND1;
  assign mag2        = sign2 ? -OPERAND2 : OPERAND2;
  assign div_by_zero = is_div_op(FUNCT3) && (OPERAND2 == '0);
  assign div_ovf     = is_div_op(FUNCT3) && !FUNCT3[0] &&
                       (OPERAND1 == MIN_INT) && (OPERAND2 == '1);
  assign special_res = div_by_zero ? (FUNCT3[1] ? OPERAND1 : '1)
                                   : (FUNCT3[1] ? '0 : OPERAND1);

  // Multiply step: low accumulator half holds the unconsumed multiplier bits.
  logic [MUL_STEP-1:0]      digit;
  logic [XLEN+MUL_STEP-1:0] mul_sum;
  logic [2*XLEN-1:0]        mul_acc;

  assign digit   = acc_q[MUL_STEP-1:0];
  assign mul_sum = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} +
                   ({{MUL_STEP{1'b0}}, opnd_q} * {{XLEN{1'b0}}, digit});
  assign mul_acc = {mul_sum, acc_q[XLEN-1:MUL_STEP]};

  // Divide step: high half is the partial remainder, low half the quotient.
  logic [XLEN-1:0] div_rem, div_quo;

  div_iter_core #(.XLEN(XLEN)) u_div_iter_core (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .quo_i     (acc_q[XLEN-1:0]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  logic [2*XLEN-1:0] step_acc, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  assign step_acc = is_div_op(f3_q) ? {div_rem, div_quo} : mul_acc;
  assign prod_fix = neg_q ? -step_acc : step_acc;
  assign quo_fix  = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
  assign rem_fix  = rem_neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];

  always_comb begin
    final_res = prod_fix[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:          final_res = prod_fix[XLEN-1:0];
      F3_DIV, F3_DIVU: final_res = quo_fix;
      F3_REM, F3_REMU: final_res = rem_fix;
      default:         final_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    // NOTE: every _d starts as a hold/default so no path can infer a latch.
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (START && !FLUSH) begin
          f3_d      = FUNCT3;
          neg_d     = sign1 ^ sign2;
          rem_neg_d = sign1;
          if (div_by_zero || div_ovf) begin
            state_d  = FIN;
            done_d   = 1'b1;
            result_d = special_res;
            cnt_d    = '0;
          end else if (is_div_op(FUNCT3)) begin
            state_d = CALC;
            busy_d  = 1'b1;
            opnd_d  = mag2;
            acc_d   = {{XLEN{1'b0}}, mag1};
            cnt_d   = DIV_ITERS;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
            opnd_d  = mag1;
            acc_d   = {{XLEN{1'b0}}, mag2};
            cnt_d   = MUL_ITERS;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = FIN;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = final_res;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An abort overrides whatever the active state decided this cycle.
    if (FLUSH && state_q != IDLE) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
      cnt_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      cnt_q     <= '0;
      f3_q      <= F3_MUL;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases, flush/reset aborts and a
// random back-to-back stream, results checked through a scoreboard queue.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN     = 32;
  localparam int MUL_STEP = 4;
  localparam int MUL_LAT  = XLEN / MUL_STEP + 1;
  localparam int DIV_LAT  = XLEN + 1;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [2:0]  FUNCT3;
  logic [31:0] OPERAND1;
  logic [31:0] OPERAND2;
  logic        FLUSH;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } exp_t;

  exp_t        score_q[$];
  exp_t        mon_e;
  logic [31:0] last_expected = '0;

  always #5 CLK = ~CLK;

  muldiv_unit #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .FUNCT3   (FUNCT3),
    .OPERAND1 (OPERAND1),
    .OPERAND2 (OPERAND2),
    .FLUSH    (FLUSH),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RESULT   (RESULT)
  );

  // Reference RV32M semantics on 64-bit arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0]        p;
    logic signed [63:0] sa, sbx, ub;
    sa  = {{32{a[31]}}, a};
    sbx = {{32{b[31]}}, b};
    ub  = {32'b0, b};
    case (f3)
      F3_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      F3_MULH:   begin p = sa * sbx; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub;  return p[63:32]; end
      F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      F3_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      F3_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: every DONE pops one expected result.
  always @(negedge CLK) begin
    if (!RESET && DONE) begin
      checks++;
      if (score_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: DONE with RESULT=%h, required no DONE", RESULT);
      end else begin
        mon_e = score_q.pop_front();
        if (RESULT !== mon_e.res) begin
          errors++;
          $display("FAIL result f3=%0d a=%h b=%h: got %h, required %h",
                   mon_e.f3, mon_e.a, mon_e.b, RESULT, mon_e.res);
        end
      end
    end
  end

  // Presents a request in the next cycle and holds START.
  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input bit track);
    @(negedge CLK);
    START    = 1'b1;
    FUNCT3   = f3;
    OPERAND1 = a;
    OPERAND2 = b;
    if (track) begin
      score_q.push_back('{f3, a, b, res});
      last_expected = res;
    end
  endtask

  // Counts cycles from the START cycle to the DONE cycle; -1 on timeout.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge CLK);
      if (BUSY === 1'b1) busy_cnt++;
      if (DONE === 1'b1) begin
        lat = c;
        break;
      end
    end
    START = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
    FUNCT3 = F3_MUL; OPERAND1 = '0; OPERAND2 = '0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({BUSY, DONE, RESULT} !== 34'd0) begin
      errors++;
      $display("FAIL reset_state: got BUSY=%b DONE=%b RESULT=%h, required 0 0 0",
               BUSY, DONE, RESULT);
    end
    RESET = 1'b0;
  endtask

  task automatic test_mul();
    int lat, busy;
    launch(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    wait_done(lat, busy);
    checks++;
    if (lat !== MUL_LAT) begin
      errors++; $display("FAIL mul_latency: got %0d, required %0d", lat, MUL_LAT);
    end
    checks++;
    if (busy !== MUL_LAT - 1) begin
      errors++; $display("FAIL mul_busy_cycles: got %0d, required %0d", busy, MUL_LAT - 1);
    end
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b0 || RESULT !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL result_hold: got DONE=%b RESULT=%h, required 0 ffffffeb", DONE, RESULT);
    end
  endtask

  task automatic test_mulh();
    logic [2:0]  f3s [3] = '{F3_MULH, F3_MULHU, F3_MULHSU};
    logic [31:0] as  [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs  [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] rs  [3] = '{32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
    int lat, busy;
    for (int i = 0; i < 3; i++) begin
      launch(f3s[i], as[i], bs[i], rs[i], 1'b1);
      wait_done(lat, busy);
      checks++;
      if (lat !== MUL_LAT) begin
        errors++; $display("FAIL mulh_latency[%0d]: got %0d, required %0d", i, lat, MUL_LAT);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3s [3] = '{F3_DIV, F3_REM, F3_DIVU};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100};
    logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'd7};
    logic [31:0] rs  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14};
    int lat, busy;
    for (int i = 0; i < 3; i++) begin
      launch(f3s[i], as[i], bs[i], rs[i], 1'b1);
      wait_done(lat, busy);
      checks++;
      if (lat !== DIV_LAT || busy !== DIV_LAT - 1) begin
        errors++;
        $display("FAIL div_timing[%0d]: got latency %0d busy %0d, required %0d %0d",
                 i, lat, busy, DIV_LAT, DIV_LAT - 1);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3s [4] = '{F3_DIVU, F3_REM, F3_DIV, F3_REM};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] rs  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lat, busy;
    for (int i = 0; i < 4; i++) begin
      launch(f3s[i], as[i], bs[i], rs[i], 1'b1);
      wait_done(lat, busy);
      checks++;
      if (lat !== 1 || busy !== 0) begin
        errors++;
        $display("FAIL special_timing[%0d]: got latency %0d busy %0d, required 1 0",
                 i, lat, busy);
      end
    end
  endtask

  task automatic test_flush();
    int lat, busy;
    logic [31:0] held;
    launch(F3_DIVU, 32'd1234, 32'd10, 32'd123, 1'b1);
    wait_done(lat, busy);
    held = last_expected;
    launch(F3_DIV, 32'd1000, 32'd3, 32'd333, 1'b0);
    repeat (10) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++; $display("FAIL flush_pre_busy: got BUSY=%b, required 1", BUSY);
    end
    FLUSH = 1'b1;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== held) begin
      errors++;
      $display("FAIL flush_abort: got BUSY=%b DONE=%b RESULT=%h, required 0 0 %h",
               BUSY, DONE, RESULT, held);
    end
    FLUSH    = 1'b0;
    START    = 1'b1;
    FUNCT3   = F3_DIVU;
    OPERAND1 = 32'd100;
    OPERAND2 = 32'd7;
    score_q.push_back('{F3_DIVU, 32'd100, 32'd7, 32'd14});
    last_expected = 32'd14;
    wait_done(lat, busy);
    checks++;
    if (lat !== DIV_LAT) begin
      errors++; $display("FAIL flush_restart_latency: got %0d, required %0d", lat, DIV_LAT);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    launch(F3_MUL, 32'd3, 32'd5, 32'd15, 1'b0);
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    START = 1'b0;
    @(negedge CLK);
    checks++;
    if ({BUSY, DONE, RESULT} !== 34'd0) begin
      errors++;
      $display("FAIL reset_mid_op: got BUSY=%b DONE=%b RESULT=%h, required 0 0 0",
               BUSY, DONE, RESULT);
    end
    RESET = 1'b0;
    @(negedge CLK);
    START    = 1'b1;
    FLUSH    = 1'b1;
    FUNCT3   = F3_MUL;
    OPERAND1 = 32'd9;
    OPERAND2 = 32'd9;
    @(negedge CLK);
    START = 1'b0;
    FLUSH = 1'b0;
    seen  = 0;
    for (int c = 0; c < 12; c++) begin
      if (BUSY !== 1'b0 || DONE !== 1'b0) seen++;
      @(negedge CLK);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL start_flush_launch: got %0d active cycles, required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int          lat, busy;
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      launch(f3, a, b, ref_op(f3, a, b), 1'b1);
      wait_done(lat, busy);
      checks++;
      if (lat !== ref_lat(f3, a, b)) begin
        errors++;
        $display("FAIL b2b_latency[%0d] f3=%0d a=%h b=%h: got %0d, required %0d",
                 i, f3, a, b, lat, ref_lat(f3, a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_reset_mid_op();
    test_back_to_back();
    repeat (3) @(negedge CLK);
    checks++;
    if (score_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending results, required 0", score_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
